// File: rtl/crc_cmd_sequencer_if.sv
// Pad-side command bus and engine handshake of the CRC command sequencer.
// master: host/engine side driving commands and engine status; slave: the sequencer.
interface crc_cmd_sequencer_if #(
   parameter int CRC_W = 32
);
   logic [1:0]       cmd;
   logic [3:0]       data_in;
   logic             eng_clr;
   logic             eng_valid;
   logic [3:0]       eng_nib;
   logic             eng_ready;
   logic             eng_busy;
   logic [CRC_W-1:0] eng_crc;
   logic [7:0]       io_out;

   modport master (
      output cmd, data_in, eng_ready, eng_busy, eng_crc,
      input  eng_clr, eng_valid, eng_nib, io_out
   );

   modport slave (
      input  cmd, data_in, eng_ready, eng_busy, eng_crc,
      output eng_clr, eng_valid, eng_nib, io_out
   );
endinterface

// File: rtl/crc_cmd_sequencer.sv
// Command sequencer for a nibble-serial CRC engine: nibble FIFO feed, CRC snapshot, nibble readout.
// Optional CRC_SEQ_XOROUT_EN applies the XOROUT mask to the snapshot; default build stores the raw CRC.
module crc_cmd_sequencer #(
   parameter int               CRC_W      = 32,
   parameter int               FIFO_DEPTH = 4,
   parameter logic [CRC_W-1:0] XOROUT     = CRC_W'(32'hFFFFFFFF)
) (
   input logic                clk,
   input logic                rst,
   crc_cmd_sequencer_if.slave bus
);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int NIBS  = CRC_W / 4;
   localparam int IDX_W = (NIBS > 1) ? $clog2(NIBS) : 1;

   localparam logic [1:0] CMD_CLEAR = 2'b01;
   localparam logic [1:0] CMD_DATA  = 2'b10;
   localparam logic [1:0] CMD_READ  = 2'b11;

`ifdef CRC_SEQ_XOROUT_EN
   localparam logic [CRC_W-1:0] SNAP_MASK = XOROUT;
`else
   // Raw snapshot: the mask collapses to zero, XOROUT has no effect in this build.
   localparam logic [CRC_W-1:0] SNAP_MASK = {CRC_W{1'b0}} & XOROUT;
`endif

   typedef enum logic [1:0] {
      S_CLEAR = 2'd0,
      S_RUN   = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           state_reg;
   state_t           state_next;
   logic [3:0]       fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic             ovf_reg;
   logic             res_valid_reg;
   logic [IDX_W-1:0] rd_idx_reg;
   logic [CRC_W-1:0] shadow_reg;

   logic       is_clear;
   logic       is_data;
   logic       is_read;
   logic       fifo_empty;
   logic       fifo_full;
   logic       push;
   logic       pop;
   logic       snapshot;
   logic       eng_clr_int;
   logic       eng_valid_int;
   logic       busy;
   logic [3:0] result_nib;
   logic [3:0] shadow_nib [NIBS];

   assign is_clear   = (bus.cmd == CMD_CLEAR);
   assign is_data    = (bus.cmd == CMD_DATA);
   assign is_read    = (bus.cmd == CMD_READ);
   assign fifo_empty = (count_reg == '0);
   assign fifo_full  = (count_reg == CNT_W'(FIFO_DEPTH));
   assign pop        = eng_valid_int && bus.eng_ready;
   // A full FIFO still takes a nibble when the head leaves in the same cycle.
   assign push       = is_data && (!fifo_full || pop);
   assign snapshot   = (state_reg == S_RUN) && is_read && fifo_empty &&
                       !eng_valid_int && !bus.eng_busy;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= S_CLEAR;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      if (is_clear) begin
         state_next = S_CLEAR;
      end else begin
         case (state_reg)
            S_CLEAR: state_next = S_RUN;
            S_RUN:   if (snapshot) state_next = S_DONE;
            S_DONE:  if (is_data) state_next = S_RUN;
            default: state_next = S_CLEAR;
         endcase
      end
   end

   // Output logic
   always_comb begin
      eng_clr_int   = 1'b0;
      eng_valid_int = 1'b0;
      case (state_reg)
         S_CLEAR: eng_clr_int = 1'b1;
         default: eng_valid_int = !fifo_empty;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_reg] <= bus.data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         count_reg     <= '0;
         ovf_reg       <= 1'b0;
         res_valid_reg <= 1'b0;
         rd_idx_reg    <= '0;
         shadow_reg    <= '0;
      end else if (is_clear) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         count_reg     <= '0;
         ovf_reg       <= 1'b0;
         res_valid_reg <= 1'b0;
         rd_idx_reg    <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
         if (push && !pop) begin
            count_reg <= count_reg + CNT_W'(1);
         end else if (pop && !push) begin
            count_reg <= count_reg - CNT_W'(1);
         end
         if (is_data && !push) begin
            ovf_reg <= 1'b1;
         end
         if (snapshot) begin
            shadow_reg    <= bus.eng_crc ^ SNAP_MASK;
            rd_idx_reg    <= '0;
            res_valid_reg <= 1'b1;
         end else if (state_reg == S_DONE && is_read) begin
            rd_idx_reg <= (rd_idx_reg == IDX_W'(NIBS - 1)) ? '0 : rd_idx_reg + IDX_W'(1);
         end
         if (state_reg == S_DONE && is_data) begin
            res_valid_reg <= 1'b0;
         end
      end
   end

   for (genvar gi = 0; gi < NIBS; gi++) begin : g_shadow_nib
      assign shadow_nib[gi] = shadow_reg[4*gi +: 4];
   end

   assign result_nib = res_valid_reg ? shadow_nib[rd_idx_reg] : 4'h0;
   assign busy       = !fifo_empty || bus.eng_busy || eng_valid_int;

   assign bus.eng_clr   = eng_clr_int;
   assign bus.eng_valid = eng_valid_int;
   assign bus.eng_nib   = fifo_empty ? 4'h0 : fifo_mem[rd_ptr_reg];
   assign bus.io_out    = {res_valid_reg, ovf_reg, fifo_full, busy, result_nib};
endmodule
